// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - RV32I multicycle control sequencer (Moore FSM)
// Define MC_MEM_WAIT_EN to stall FETCH/MEMREAD/MEMWRITE until mem_ready.
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic [2:0] alu_control,
  output logic       instr_done,
  output logic       illegal_op
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BEQ
  } state_t;

  state_t     state, state_next;
  logic       mem_ok;
  logic [1:0] alu_op;
  logic [1:0] imm_from_op;

`ifdef MC_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif

  always_comb begin
    unique case (op)
      OP_SW:   imm_from_op = 2'b01;
      OP_BEQ:  imm_from_op = 2'b10;
      OP_JAL:  imm_from_op = 2'b11;
      default: imm_from_op = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    imm_src     = 2'b00;
    reg_write   = 1'b0;
    alu_op      = 2'b00;
    alu_control = 3'b000;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;

    unique case (state)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write   = mem_ok;
        ir_write   = mem_ok;
        if (mem_ok) state_next = S_DECODE;
      end
      S_DECODE: begin
        // ALUOut <= OldPC + imm: branch/jump target ready for BEQ and JAL
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = imm_from_op;
        unique case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECR;
          OP_I:         state_next = S_EXECI;
          OP_JAL:       state_next = S_JAL;
          OP_BEQ:       state_next = S_BEQ;
          default: begin
            illegal_op = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        imm_src    = imm_from_op;
        state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ok) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        imm_src    = 2'b01;
        mem_write  = mem_ok;
        instr_done = mem_ok;
        if (mem_ok) state_next = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b10;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = 2'b10;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        imm_src    = 2'b11;
        pc_write   = 1'b1;
        state_next = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a  = 2'b10;
        imm_src    = 2'b10;
        alu_op     = 2'b01;
        pc_write   = zero;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase

    unique case (alu_op)
      2'b01: alu_control = 3'b001;
      2'b10: begin
        unique case (funct3)
          3'b000:  alu_control = (op == OP_R && funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase

    // Reset cycle drives nothing, so an abandoned instruction cannot commit
    if (rst) begin
      pc_write    = 1'b0;
      adr_src     = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      imm_src     = 2'b00;
      reg_write   = 1'b0;
      alu_control = 3'b000;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;
    end
  end

endmodule
